// File: rtl/filtro_secuenciador_if.sv
// Handshake/control bundle between the sample sequencer and its datapath.
// FILTRO_OVR_COUNT_EN adds the saturating dropped-tick counter ovr_count.
interface filtro_secuenciador_if;
    logic       sample_tick;
    logic [1:0] band_req;
    logic       ovr_clr;
    logic [1:0] band_sel;
    logic [2:0] tap_idx;
    logic       acc_clr;
    logic       mac_en;
    logic       y_load;
    logic       done;
    logic       busy;
    logic       overrun;
`ifdef FILTRO_OVR_COUNT_EN
    logic [7:0] ovr_count;

    modport master (
        output sample_tick, band_req, ovr_clr,
        input  band_sel, tap_idx, acc_clr, mac_en,
        input  y_load, done, busy, overrun, ovr_count
    );
    modport slave (
        input  sample_tick, band_req, ovr_clr,
        output band_sel, tap_idx, acc_clr, mac_en,
        output y_load, done, busy, overrun, ovr_count
    );
`else
    modport master (
        output sample_tick, band_req, ovr_clr,
        input  band_sel, tap_idx, acc_clr, mac_en,
        input  y_load, done, busy, overrun
    );
    modport slave (
        input  sample_tick, band_req, ovr_clr,
        output band_sel, tap_idx, acc_clr, mac_en,
        output y_load, done, busy, overrun
    );
`endif
endinterface

// File: rtl/filtro_secuenciador.sv
// Per-sample biquad control sequencer: IDLE->LOAD->MAC x N_TAPS->WRITE->DONE.
// Define FILTRO_OVR_COUNT_EN to add the 8-bit saturating ovr_count output.
module filtro_secuenciador #(
    parameter int N_TAPS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    filtro_secuenciador_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] LAST    = 3'(N_TAPS - 1);

    logic [2:0] r_state;
    logic [1:0] r_band_sel;
    logic [2:0] r_tap_idx;
    logic       r_acc_clr;
    logic       r_mac_en;
    logic       r_y_load;
    logic       r_done;
    logic       r_busy;
    logic       r_overrun;
    logic       w_drop;

    // Outputs are registered alongside the state, so they are loaded
    // with the values belonging to the state being entered.
    assign w_drop = bus.sample_tick & r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_band_sel <= 2'b00;
            r_tap_idx  <= 3'd0;
            r_acc_clr  <= 1'b0;
            r_mac_en   <= 1'b0;
            r_y_load   <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.sample_tick) begin
                        r_state    <= S_LOAD;
                        r_band_sel <= bus.band_req;
                        r_tap_idx  <= 3'd0;
                        r_acc_clr  <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state   <= S_MAC;
                    r_acc_clr <= 1'b0;
                    r_mac_en  <= 1'b1;
                    r_tap_idx <= 3'd0;
                end
                S_MAC: begin
                    if (r_tap_idx == LAST) begin
                        r_state   <= S_WRITE;
                        r_mac_en  <= 1'b0;
                        r_y_load  <= 1'b1;
                        r_tap_idx <= 3'd0;
                    end else begin
                        r_tap_idx <= r_tap_idx + 3'd1;
                    end
                end
                S_WRITE: begin
                    r_state  <= S_DONE;
                    r_y_load <= 1'b0;
                    r_done   <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_tap_idx <= 3'd0;
                    r_acc_clr <= 1'b0;
                    r_mac_en  <= 1'b0;
                    r_y_load  <= 1'b0;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // A new drop outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef FILTRO_OVR_COUNT_EN
    logic [7:0] r_ovr_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovr_count <= 8'd0;
        end else if (w_drop) begin
            if (r_ovr_count != 8'hFF) begin
                r_ovr_count <= r_ovr_count + 8'd1;
            end
        end else if (bus.ovr_clr) begin
            r_ovr_count <= 8'd0;
        end
    end

    assign bus.ovr_count = r_ovr_count;
`endif

    assign bus.band_sel = r_band_sel;
    assign bus.tap_idx  = r_tap_idx;
    assign bus.acc_clr  = r_acc_clr;
    assign bus.mac_en   = r_mac_en;
    assign bus.y_load   = r_y_load;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;
    assign bus.overrun  = r_overrun;
endmodule
